// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU classes,
// FSM states and datapath select codes.
package mips_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ST_W     = 4;
    localparam int unsigned ALUOP_BW = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] FUNCT_JR = 6'h08;

    localparam logic [ALUOP_BW-1:0] ALUOP_RTYPE = 3'b111;
    localparam logic [ALUOP_BW-1:0] ALUOP_ADD   = 3'b100;
    localparam logic [ALUOP_BW-1:0] ALUOP_OR    = 3'b101;
    localparam logic [ALUOP_BW-1:0] ALUOP_SUB   = 3'b010;
    localparam logic [ALUOP_BW-1:0] ALUOP_NONE  = 3'b000;

    localparam logic [ST_W-1:0] S_IDLE      = 4'd0;
    localparam logic [ST_W-1:0] S_FETCH     = 4'd1;
    localparam logic [ST_W-1:0] S_DECODE    = 4'd2;
    localparam logic [ST_W-1:0] S_R_EXEC    = 4'd3;
    localparam logic [ST_W-1:0] S_R_WB      = 4'd4;
    localparam logic [ST_W-1:0] S_I_EXEC    = 4'd5;
    localparam logic [ST_W-1:0] S_I_WB      = 4'd6;
    localparam logic [ST_W-1:0] S_MEM_ADDR  = 4'd7;
    localparam logic [ST_W-1:0] S_MEM_READ  = 4'd8;
    localparam logic [ST_W-1:0] S_MEM_WB    = 4'd9;
    localparam logic [ST_W-1:0] S_MEM_WRITE = 4'd10;
    localparam logic [ST_W-1:0] S_BRANCH    = 4'd11;
    localparam logic [ST_W-1:0] S_JUMP      = 4'd12;
    localparam logic [ST_W-1:0] S_JAL       = 4'd13;
    localparam logic [ST_W-1:0] S_JR        = 4'd14;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_LUI    = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    // State following DECODE; S_FETCH doubles as the "unsupported opcode" result.
    function automatic logic [ST_W-1:0] decode_target(input logic [OP_W-1:0] op,
                                                       input logic [OP_W-1:0] funct);
        logic [ST_W-1:0] nxt;
        nxt = S_FETCH;
        case (op)
            OP_RTYPE:               nxt = (funct == FUNCT_JR) ? S_JR : S_R_EXEC;
            OP_ADDI, OP_ORI, OP_LUI: nxt = S_I_EXEC;
            OP_LW, OP_SW:           nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE:         nxt = S_BRANCH;
            OP_J:                   nxt = S_JUMP;
            OP_JAL:                 nxt = S_JAL;
            default:                nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control-word decode for the multicycle controller.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic [ST_W-1:0]    i_state,
    input  logic [OP_W-1:0]    i_op_q,
    input  logic [OP_W-1:0]    i_op,
    input  logic [OP_W-1:0]    i_funct,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_pc_write_c,
    output logic               o_iord_c,
    output logic               o_mem_read_c,
    output logic               o_mem_write_c,
    output logic               o_ir_write_c,
    output logic [1:0]         o_memto_reg_c,
    output logic [1:0]         o_reg_dst_c,
    output logic               o_reg_write_c,
    output logic               o_alu_src_a_c,
    output logic [1:0]         o_alu_src_b_c,
    output logic [ALUOP_W-1:0] o_alu_op_c,
    output logic [1:0]         o_pc_source_c,
    output logic               o_illegal_op_c,
    output logic               o_instr_retired_c
);

    logic [ALUOP_BW-1:0] w_alu_op;

    assign o_alu_op_c = ALUOP_W'(w_alu_op);

    always_comb begin
        o_pc_write_c      = 1'b0;
        o_iord_c          = 1'b0;
        o_mem_read_c      = 1'b0;
        o_mem_write_c     = 1'b0;
        o_ir_write_c      = 1'b0;
        o_memto_reg_c     = M2R_ALUOUT;
        o_reg_dst_c       = RDST_RT;
        o_reg_write_c     = 1'b0;
        o_alu_src_a_c     = 1'b0;
        o_alu_src_b_c     = SRCB_RT;
        w_alu_op          = ALUOP_NONE;
        o_pc_source_c     = PCS_ALU;
        o_illegal_op_c    = 1'b0;
        o_instr_retired_c = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_read_c  = 1'b1;
                o_alu_src_b_c = SRCB_FOUR;
                w_alu_op      = ALUOP_ADD;
                o_ir_write_c  = i_mem_ready;
                o_pc_write_c  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b_c     = SRCB_IMM_SH2;
                w_alu_op          = ALUOP_ADD;
                o_illegal_op_c    = (decode_target(i_op, i_funct) == S_FETCH);
                o_instr_retired_c = (decode_target(i_op, i_funct) == S_FETCH);
            end
            S_R_EXEC: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_RT;
                w_alu_op      = ALUOP_RTYPE;
            end
            S_R_WB: begin
                o_reg_dst_c       = RDST_RD;
                o_reg_write_c     = 1'b1;
                o_instr_retired_c = 1'b1;
            end
            S_I_EXEC: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_IMM;
                w_alu_op      = (i_op_q == OP_ORI) ? ALUOP_OR :
                                (i_op_q == OP_LUI) ? ALUOP_NONE : ALUOP_ADD;
            end
            S_I_WB: begin
                o_reg_write_c     = 1'b1;
                o_memto_reg_c     = (i_op_q == OP_LUI) ? M2R_LUI : M2R_ALUOUT;
                o_instr_retired_c = 1'b1;
            end
            S_MEM_ADDR: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_IMM;
                w_alu_op      = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_mem_read_c = 1'b1;
                o_iord_c     = 1'b1;
            end
            S_MEM_WB: begin
                o_memto_reg_c     = M2R_MDR;
                o_reg_write_c     = 1'b1;
                o_instr_retired_c = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_write_c     = 1'b1;
                o_iord_c          = 1'b1;
                o_instr_retired_c = i_mem_ready;
            end
            S_BRANCH: begin
                o_alu_src_a_c     = 1'b1;
                o_alu_src_b_c     = SRCB_RT;
                w_alu_op          = ALUOP_SUB;
                o_pc_source_c     = PCS_ALUOUT;
                o_pc_write_c      = (i_op_q == OP_BNE) ? ~i_zero : i_zero;
                o_instr_retired_c = 1'b1;
            end
            S_JUMP: begin
                o_pc_source_c     = PCS_JUMP;
                o_pc_write_c      = 1'b1;
                o_instr_retired_c = 1'b1;
            end
            // Register file latches the already-incremented PC into r31 on this edge.
            S_JAL: begin
                o_pc_source_c     = PCS_JUMP;
                o_pc_write_c      = 1'b1;
                o_reg_dst_c       = RDST_RA;
                o_memto_reg_c     = M2R_PC;
                o_reg_write_c     = 1'b1;
                o_instr_retired_c = 1'b1;
            end
            S_JR: begin
                o_pc_source_c     = PCS_RS;
                o_pc_write_c      = 1'b1;
                o_instr_retired_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, next-state logic, latched opcode
// and retired-instruction counter around a combinational control decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W       = 3,
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic               InstrRetired,
    output logic [CNT_W-1:0]   InstrCount
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic [OP_W-1:0] r_op;
    logic            w_mem_ready;

    assign w_mem_ready = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = decode_target(OP, Funct);
            S_R_EXEC:    w_next = S_R_WB;
            S_I_EXEC:    w_next = S_I_WB;
            S_MEM_ADDR:  w_next = (r_op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = w_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = w_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    // Opcode is only trusted in DECODE; later states use this copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op       <= '0;
            InstrCount <= '0;
        end else begin
            if (r_state == S_DECODE) r_op <= OP;
            if (InstrRetired)        InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    multicycle_ctrl_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_state           (r_state),
        .i_op_q            (r_op),
        .i_op              (OP),
        .i_funct           (Funct),
        .i_zero            (Zero),
        .i_mem_ready       (w_mem_ready),
        .o_pc_write_c      (PCWrite),
        .o_iord_c          (IorD),
        .o_mem_read_c      (MemRead),
        .o_mem_write_c     (MemWrite),
        .o_ir_write_c      (IRWrite),
        .o_memto_reg_c     (MemtoReg),
        .o_reg_dst_c       (RegDst),
        .o_reg_write_c     (RegWrite),
        .o_alu_src_a_c     (ALUSrcA),
        .o_alu_src_b_c     (ALUSrcB),
        .o_alu_op_c        (ALUOp),
        .o_pc_source_c     (PCSource),
        .o_illegal_op_c    (IllegalOp),
        .o_instr_retired_c (InstrRetired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle check of the multicycle controller's control word and
// retired-instruction counter (CNT_W=4 so wraparound is reachable).
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic       IllegalOp, InstrRetired;
    logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] InstrCount;
    logic [19:0] w_cw;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control #(
        .ALUOP_W       (3),
        .MEM_HANDSHAKE (1),
        .CNT_W         (4)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .OP           (OP),
        .Funct        (Funct),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .PCWrite      (PCWrite),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .MemtoReg     (MemtoReg),
        .RegDst       (RegDst),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .PCSource     (PCSource),
        .IllegalOp    (IllegalOp),
        .InstrRetired (InstrRetired),
        .InstrCount   (InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: PCWrite IorD MemRead MemWrite IRWrite | MemtoReg RegDst RegWrite |
    //              ALUSrcA ALUSrcB ALUOp PCSource | IllegalOp InstrRetired
    assign w_cw = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, InstrRetired};

    localparam logic [19:0] E_ZERO     = 20'h0;
    localparam logic [19:0] E_FETCH    = {5'b10101, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b100, 2'b00, 2'b00};
    localparam logic [19:0] E_FETCH_W  = {5'b00100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b100, 2'b00, 2'b00};
    localparam logic [19:0] E_DECODE   = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b100, 2'b00, 2'b00};
    localparam logic [19:0] E_DEC_ILL  = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b100, 2'b00, 2'b11};
    localparam logic [19:0] E_R_EXEC   = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00, 2'b00};
    localparam logic [19:0] E_R_WB     = {5'b00000, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [19:0] E_IMM_ADD  = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b100, 2'b00, 2'b00};
    localparam logic [19:0] E_IMM_OR   = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b101, 2'b00, 2'b00};
    localparam logic [19:0] E_IMM_LUI  = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b000, 2'b00, 2'b00};
    localparam logic [19:0] E_I_WB     = {5'b00000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [19:0] E_I_WB_LUI = {5'b00000, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [19:0] E_MEM_RD   = {5'b01100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [19:0] E_MEM_WB   = {5'b00000, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [19:0] E_MEM_WR   = {5'b01010, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [19:0] E_BR_T     = {5'b10000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b010, 2'b01, 2'b01};
    localparam logic [19:0] E_BR_N     = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b010, 2'b01, 2'b01};
    localparam logic [19:0] E_JUMP     = {5'b10000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 2'b01};
    localparam logic [19:0] E_JAL      = {5'b10000, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 2'b10, 2'b01};
    localparam logic [19:0] E_JR       = {5'b10000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b11, 2'b01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, check the control word just after.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input logic rdy, input logic [19:0] exp);
        @(negedge clk);
        OP = op; Funct = fn; Zero = zero; MemReady = rdy;
        #1;
        check(tag, 32'(w_cw), 32'(exp));
    endtask

    // Fetch with OP held at an illegal value, plus a check of the count so far.
    task automatic fetch(input string tag, input logic [3:0] cnt);
        cyc({tag, ".fetch"}, 6'h3F, 6'h3F, 1'b0, 1'b1, E_FETCH);
        check({tag, ".count"}, 32'(InstrCount), 32'(cnt));
    endtask

    task automatic illegal(input string tag, input logic [3:0] cnt);
        fetch(tag, cnt);
        cyc({tag, ".decode"}, 6'h3F, 6'h00, 1'b0, 1'b1, E_DEC_ILL);
    endtask

    initial begin
        rst_n = 1'b0; OP = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b0;
        @(negedge clk); #1;
        check("reset.cw", 32'(w_cw), 32'(E_ZERO));
        check("reset.count", 32'(InstrCount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b1;
        #1;
        check("idle.cw", 32'(w_cw), 32'(E_ZERO));

        // ADD: 4 cycles, OP garbage outside DECODE must not matter
        fetch("add", 4'd0);
        cyc("add.decode", 6'h00, 6'h20, 1'b0, 1'b1, E_DECODE);
        cyc("add.exec",   6'h3F, 6'h08, 1'b1, 1'b0, E_R_EXEC);
        cyc("add.wb",     6'h3F, 6'h08, 1'b1, 1'b0, E_R_WB);

        // LW with two memory wait states: 7 cycles
        fetch("lw", 4'd1);
        cyc("lw.decode", 6'h23, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("lw.addr",   6'h2B, 6'h00, 1'b0, 1'b0, E_IMM_ADD);
        cyc("lw.wait1",  6'h2B, 6'h00, 1'b0, 1'b0, E_MEM_RD);
        cyc("lw.wait2",  6'h2B, 6'h00, 1'b0, 1'b0, E_MEM_RD);
        cyc("lw.rdy",    6'h2B, 6'h00, 1'b0, 1'b1, E_MEM_RD);
        cyc("lw.wb",     6'h2B, 6'h00, 1'b0, 1'b0, E_MEM_WB);

        // SW preceded by one fetch wait state
        cyc("sw.fetchwait", 6'h3F, 6'h00, 1'b0, 1'b0, E_FETCH_W);
        fetch("sw", 4'd2);
        cyc("sw.decode", 6'h2B, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("sw.addr",   6'h23, 6'h00, 1'b0, 1'b1, E_IMM_ADD);
        cyc("sw.write",  6'h23, 6'h00, 1'b0, 1'b1, E_MEM_WR);

        fetch("beq", 4'd3);
        cyc("beq.decode", 6'h04, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("beq.branch", 6'h05, 6'h00, 1'b1, 1'b1, E_BR_T);
        fetch("bne", 4'd4);
        cyc("bne.decode", 6'h05, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("bne.branch", 6'h04, 6'h00, 1'b1, 1'b1, E_BR_N);

        fetch("jal", 4'd5);
        cyc("jal.decode", 6'h03, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("jal.exec",   6'h00, 6'h00, 1'b0, 1'b1, E_JAL);
        fetch("jr", 4'd6);
        cyc("jr.decode", 6'h00, 6'h08, 1'b0, 1'b1, E_DECODE);
        cyc("jr.exec",   6'h00, 6'h20, 1'b0, 1'b1, E_JR);

        fetch("addi", 4'd7);
        cyc("addi.decode", 6'h08, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("addi.exec",   6'h0F, 6'h00, 1'b0, 1'b1, E_IMM_ADD);
        cyc("addi.wb",     6'h0F, 6'h00, 1'b0, 1'b1, E_I_WB);
        fetch("ori", 4'd8);
        cyc("ori.decode", 6'h0D, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("ori.exec",   6'h0F, 6'h00, 1'b0, 1'b1, E_IMM_OR);
        cyc("ori.wb",     6'h0F, 6'h00, 1'b0, 1'b1, E_I_WB);
        fetch("lui", 4'd9);
        cyc("lui.decode", 6'h0F, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("lui.exec",   6'h08, 6'h00, 1'b0, 1'b1, E_IMM_LUI);
        cyc("lui.wb",     6'h08, 6'h00, 1'b0, 1'b1, E_I_WB_LUI);

        fetch("j", 4'd10);
        cyc("j.decode", 6'h02, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("j.exec",   6'h03, 6'h00, 1'b0, 1'b1, E_JUMP);

        // Illegal opcodes retire in DECODE; the 4-bit counter wraps 15 -> 0
        illegal("ill1", 4'd11);
        illegal("ill2", 4'd12);
        illegal("ill3", 4'd13);
        illegal("ill4", 4'd14);
        illegal("ill5", 4'd15);
        illegal("ill6", 4'd0);
        fetch("post_ill", 4'd1);

        // Reset asserted mid-MEM_READ abandons the access
        cyc("rst_lw.decode", 6'h23, 6'h00, 1'b0, 1'b1, E_DECODE);
        cyc("rst_lw.addr",   6'h00, 6'h00, 1'b0, 1'b0, E_IMM_ADD);
        cyc("rst_lw.wait",   6'h00, 6'h00, 1'b0, 1'b0, E_MEM_RD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.cw", 32'(w_cw), 32'(E_ZERO));
        check("midrst.count", 32'(InstrCount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b1;
        #1;
        check("midrst.idle", 32'(w_cw), 32'(E_ZERO));
        fetch("add2", 4'd0);
        cyc("add2.decode", 6'h00, 6'h25, 1'b0, 1'b1, E_DECODE);
        cyc("add2.exec",   6'h00, 6'h25, 1'b0, 1'b1, E_R_EXEC);
        cyc("add2.wb",     6'h00, 6'h25, 1'b0, 1'b1, E_R_WB);
        fetch("final", 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
